// File: rtl/fc_pkg.sv
// Shared types and width helpers for the FC sequencer.
package fc_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  // Address/counter width for a range of n values, never narrower than 1 bit
  // so degenerate sizes (n=1) still yield a legal vector.
  function automatic int aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_rd_delay.sv
// Fixed-depth strobe delay that lines the issue pulse up with memory read data.
module fc_rd_delay #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  logic [LAT:0] vld_pipe;

  assign vld_pipe[0] = in;

  for (genvar i = 1; i <= LAT; i++) begin : g_stg
    // One register stage per cycle of read latency; cleared on reset.
    always_ff @(posedge clk) begin
      if (reset) vld_pipe[i] <= 1'b0;
      else       vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign out = vld_pipe[LAT];

endmodule

// File: rtl/fc_seq_ctrl.sv
// Sequencer for the matrix-vector FC datapath: loads the vector, then issues
// M rows of N read/MAC operations and hands each row result downstream.
module fc_seq_ctrl
  import fc_pkg::*;
#(
  parameter int M      = 8,
  parameter int N      = 10,
  parameter int RD_LAT = 1,
  localparam int XW    = aw(N),
  localparam int WW    = aw(M * N),
  localparam int RW    = aw(M),
  localparam int DW    = aw(RD_LAT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          input_valid,
  output logic          input_ready,
  output logic          output_valid,
  input  logic          output_ready,
  output logic [XW-1:0] addr_x,
  output logic          wr_en_x,
  output logic [WW-1:0] addr_w,
  output logic          clear_acc,
  output logic          en_acc
);

  state_t        state, state_nx;
  logic [XW-1:0] cnt, cnt_nx;      // load count in LOAD, column in MAC
  logic [RW-1:0] row, row_nx;
  logic [WW-1:0] waddr, waddr_nx;  // weight address; holds last issue outside MAC
  logic [DW-1:0] dcnt, dcnt_nx;
  logic          issue;
  logic          en_dly;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
      cnt   <= '0;
      row   <= '0;
      waddr <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      row   <= row_nx;
      waddr <= waddr_nx;
      dcnt  <= dcnt_nx;
    end
  end

  // Next-state and output decode. The weight address only advances between
  // issues of a row and on the OUT->MAC transition, so it still shows the
  // last issued address while draining and waiting for the handshake.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    row_nx       = row;
    waddr_nx     = waddr;
    dcnt_nx      = dcnt;
    input_ready  = 1'b0;
    wr_en_x      = 1'b0;
    output_valid = 1'b0;
    clear_acc    = 1'b0;
    issue        = 1'b0;
    addr_x       = cnt;
    addr_w       = waddr;
    case (state)
      LOAD: begin
        input_ready = 1'b1;
        wr_en_x     = input_valid;
        if (input_valid) begin
          if (cnt == XW'(N - 1)) begin
            state_nx = MAC;
            cnt_nx   = '0;
            row_nx   = '0;
            waddr_nx = '0;
          end else begin
            cnt_nx = cnt + XW'(1);
          end
        end
      end
      MAC: begin
        issue     = 1'b1;
        clear_acc = (cnt == '0);
        if (cnt == XW'(N - 1)) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
          dcnt_nx  = '0;
        end else begin
          cnt_nx   = cnt + XW'(1);
          waddr_nx = waddr + WW'(1);
        end
      end
      DRAIN: begin
        if (dcnt == DW'(RD_LAT - 1)) state_nx = OUT;
        else                         dcnt_nx  = dcnt + DW'(1);
      end
      OUT: begin
        output_valid = 1'b1;
        if (output_ready) begin
          if (row == RW'(M - 1)) begin
            state_nx = LOAD;
            cnt_nx   = '0;
            row_nx   = '0;
            waddr_nx = '0;
          end else begin
            state_nx = MAC;
            row_nx   = row + RW'(1);
            waddr_nx = waddr + WW'(1);
          end
        end
      end
      default: state_nx = LOAD;
    endcase
    if (reset) begin
      input_ready  = 1'b0;
      wr_en_x      = 1'b0;
      output_valid = 1'b0;
      clear_acc    = 1'b0;
      issue        = 1'b0;
      addr_x       = '0;
      addr_w       = '0;
    end
  end

  fc_rd_delay #(.LAT(RD_LAT)) u_rd_delay (
    .clk   (clk),
    .reset (reset),
    .in    (issue),
    .out   (en_dly)
  );

  assign en_acc = en_dly & ~reset;

endmodule

// File: tb/tb_fc_seq_ctrl.sv
// Self-checking bench for fc_seq_ctrl: directed scenarios with literal
// expectations plus randomized handshakes/resets against a cycle model.
module tb_fc_seq_ctrl;

  localparam int M      = 8;
  localparam int N      = 10;
  localparam int RD_LAT = 1;
  localparam int XW     = (N > 1) ? $clog2(N) : 1;
  localparam int WW     = (M * N > 1) ? $clog2(M * N) : 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          input_valid;
  logic          input_ready;
  logic          output_valid;
  logic          output_ready;
  logic [XW-1:0] addr_x;
  logic          wr_en_x;
  logic [WW-1:0] addr_w;
  logic          clear_acc;
  logic          en_acc;

  int checks = 0;
  int errors = 0;

  fc_seq_ctrl #(.M(M), .N(N), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .addr_x       (addr_x),
    .wr_en_x      (wr_en_x),
    .addr_w       (addr_w),
    .clear_acc    (clear_acc),
    .en_acc       (en_acc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle model: either loading (count of accepted words) or computing row
  // m_row at step m_t, where step 0..N-1 are issues, N..N+RD_LAT-1 drain,
  // and step N+RD_LAT presents the result until the handshake.
  bit m_load = 1'b1;
  int m_cnt  = 0;
  int m_row  = 0;
  int m_t    = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_input_ready", input_ready, 0);
      chk("rst_output_valid", output_valid, 0);
      chk("rst_wr_en_x", wr_en_x, 0);
      chk("rst_clear_acc", clear_acc, 0);
      chk("rst_en_acc", en_acc, 0);
      chk("rst_addr_x", addr_x, 0);
      chk("rst_addr_w", addr_w, 0);
      m_load = 1'b1;
      m_cnt  = 0;
      m_row  = 0;
      m_t    = 0;
    end else if (m_load) begin
      chk("ld_input_ready", input_ready, 1);
      chk("ld_wr_en_x", wr_en_x, input_valid);
      chk("ld_addr_x", addr_x, m_cnt);
      chk("ld_addr_w", addr_w, 0);
      chk("ld_clear_acc", clear_acc, 0);
      chk("ld_en_acc", en_acc, 0);
      chk("ld_output_valid", output_valid, 0);
      if (input_valid) begin
        m_cnt++;
        if (m_cnt == N) begin
          m_load = 1'b0;
          m_row  = 0;
          m_t    = 0;
        end
      end
    end else begin
      bit e_ov;
      e_ov = (m_t == N + RD_LAT);
      chk("cp_input_ready", input_ready, 0);
      chk("cp_wr_en_x", wr_en_x, 0);
      chk("cp_clear_acc", clear_acc, int'(m_t == 0));
      chk("cp_en_acc", en_acc, int'(m_t >= RD_LAT && m_t < N + RD_LAT));
      chk("cp_output_valid", output_valid, int'(e_ov));
      chk("cp_addr_w", addr_w, m_row * N + ((m_t < N) ? m_t : N - 1));
      if (m_t < N) chk("cp_addr_x", addr_x, m_t);
      if (e_ov) begin
        if (output_ready) begin
          if (m_row == M - 1) begin
            m_load = 1'b1;
            m_cnt  = 0;
          end else begin
            m_row++;
            m_t = 0;
          end
        end
      end else begin
        m_t++;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset        = 1'b1;
    input_valid  = 1'b0;
    output_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int first_ov, ret, hs, last_aw, len, wrn, ovc;
    reset        = 1'b1;
    input_valid  = 1'b0;
    output_ready = 1'b1;

    // Full vector, no stalls.
    do_reset();
    input_valid = 1'b1;
    first_ov = -1; ret = -1; hs = 0; last_aw = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("t1_ready_c0", input_ready, 1);
        chk("t1_addr_x_c0", addr_x, 0);
        chk("t1_wr_c0", wr_en_x, 1);
      end
      if (output_valid && first_ov < 0) first_ov = c;
      if (output_valid && output_ready) begin
        hs++;
        last_aw = addr_w;
      end
      if (c >= N && input_ready) begin
        ret = c;
        break;
      end
      @(posedge clk); #1;
    end
    chk("t1_first_ov_cycle", first_ov, 21);
    chk("t1_ready_return_cycle", ret, 106);
    chk("t1_handshakes", hs, 8);
    chk("t1_last_addr_w", last_aw, 79);

    // Alternating input_valid: one write per accepted word.
    do_reset();
    len = -1; wrn = 0;
    for (int c = 0; c < 100; c++) begin
      input_valid = (c % 2 == 0);
      @(negedge clk);
      if (!input_ready) begin
        len = c;
        break;
      end
      if (wr_en_x) begin
        chk("t2_addr_x_seq", addr_x, wrn);
        wrn++;
      end
      @(posedge clk); #1;
    end
    chk("t2_load_len", len, 19);
    chk("t2_writes", wrn, 10);

    // Output stall of 5 cycles on row 2.
    do_reset();
    input_valid = 1'b1;
    hs = 0; ovc = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (hs == 3) begin
        chk("t3_next_addr_w", addr_w, 30);
        chk("t3_next_clear", clear_acc, 1);
        break;
      end
      if (output_valid && hs == 2) begin
        ovc++;
        chk("t3_stall_addr_w", addr_w, 29);
        chk("t3_stall_en_acc", en_acc, 0);
        chk("t3_stall_clear", clear_acc, 0);
      end
      if (output_valid && output_ready) hs++;
      @(posedge clk); #1;
      output_ready = (hs < 2) || (ovc >= 5);
    end
    chk("t3_handshakes", hs, 3);
    chk("t3_ov_len", ovc, 6);

    // Randomized traffic with occasional mid-operation resets.
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      reset        = ($urandom_range(0, 299) == 0);
      input_valid  = ($urandom_range(0, 3) != 0);
      output_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
